// File: rtl/ex_stage_mc_if.sv
// ex_stage_mc_if: groups the ID/EX-side operand, control and forwarding inputs together with
// the registered EX/MEM outputs of ex_stage_mc.
//   master: pipeline side (drives instruction/forward/flush, reads stall and results)
//   slave : execute stage (ex_stage_mc)
// Signals:
//   id_valid, rs1_data, rs2_data, immediate, alu_src, alu_op, is_muldiv, muldiv_op,
//   forward_a, forward_b, alu_result_mem, wb_data, flush  -> into EX
//   ex_stall, result, result_valid, zero_flag, rs2_fwd     -> out of EX
interface ex_stage_mc_if #(
    parameter int unsigned XLEN = 32
) ();
    logic            id_valid;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] immediate;
    logic            alu_src;
    logic [3:0]      alu_op;
    logic            is_muldiv;
    logic [2:0]      muldiv_op;
    logic [1:0]      forward_a;
    logic [1:0]      forward_b;
    logic [XLEN-1:0] alu_result_mem;
    logic [XLEN-1:0] wb_data;
    logic            flush;
    logic            ex_stall;
    logic [XLEN-1:0] result;
    logic            result_valid;
    logic            zero_flag;
    logic [XLEN-1:0] rs2_fwd;

    modport master (
        output id_valid, rs1_data, rs2_data, immediate, alu_src, alu_op, is_muldiv, muldiv_op,
               forward_a, forward_b, alu_result_mem, wb_data, flush,
        input  ex_stall, result, result_valid, zero_flag, rs2_fwd
    );

    modport slave (
        input  id_valid, rs1_data, rs2_data, immediate, alu_src, alu_op, is_muldiv, muldiv_op,
               forward_a, forward_b, alu_result_mem, wb_data, flush,
        output ex_stall, result, result_valid, zero_flag, rs2_fwd
    );
endinterface

// File: rtl/ex_stage_mc.sv
// ex_stage_mc: execute stage with operand forwarding, single-cycle integer ALU and an iterative
// RV32M unit (shift-add multiply, restoring divide on magnitudes, sign fix-up at the end).
// Results are registered (EX/MEM register). ex_stall holds the front end while a mul/div runs.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : ex_stage_mc_if.slave (instruction, forwarding, flush in; stall/results out)
// Optional build macro EX_MULDIV_EARLY_EN: divide-by-zero, signed overflow and multiply by a
// zero operand skip the iterations (1 stall cycle). Undefined: fixed XLEN+1 stall cycles.
module ex_stage_mc #(
    parameter int unsigned XLEN = 32
) (
    input logic          clk,
    input logic          rst_n,
    ex_stage_mc_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(XLEN) + 1;
    localparam int unsigned SH_W  = $clog2(XLEN);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0]   acc_q, acc_d;        // mul: product high half; div: partial remainder
    logic [XLEN-1:0]   lo_q, lo_d;          // mul: product low/multiplier; div: quotient/dividend
    logic [XLEN-1:0]   addend_q, addend_d;  // mul: |multiplicand|; div: |divisor|
    logic [XLEN-1:0]   regb_q, regb_d;
    logic [2:0]        op_q, op_d;
    logic              neg_quo_q, neg_quo_d; // negate product / quotient at the end
    logic              neg_rem_q, neg_rem_d;
    logic [XLEN-1:0]   result_q, result_d, rs2_fwd_q, rs2_fwd_d;
    logic              result_valid_q, result_valid_d, zero_flag_q, zero_flag_d;

    function automatic logic [XLEN-1:0] fwd(input logic [1:0] sel, input logic [XLEN-1:0] rf,
                                            input logic [XLEN-1:0] mem, input logic [XLEN-1:0] wb);
        case (sel)
            2'b01:   return mem;
            2'b10:   return wb;
            default: return rf;
        endcase
    endfunction

    logic [XLEN-1:0] op_a, reg_b, op_b, alu_res, mag_a, mag_b;
    logic [SH_W-1:0] shamt;
    logic            md_div, a_signed, b_signed, sa, sb, b_zero, start;
    logic [XLEN:0]   sum, shifted, diff;
    logic [2*XLEN-1:0] prod, prod_fix;
    logic [XLEN-1:0] quo_fix, rem_fix, md_res;

    always_comb begin
        op_a  = fwd(bus.forward_a, bus.rs1_data, bus.alu_result_mem, bus.wb_data);
        reg_b = fwd(bus.forward_b, bus.rs2_data, bus.alu_result_mem, bus.wb_data);
        op_b  = bus.alu_src ? bus.immediate : reg_b;
        shamt = op_b[SH_W-1:0];
        case (bus.alu_op)
            4'd0:    alu_res = op_a + op_b;
            4'd1:    alu_res = op_a - op_b;
            4'd2:    alu_res = op_a & op_b;
            4'd3:    alu_res = op_a | op_b;
            4'd4:    alu_res = op_a ^ op_b;
            4'd5:    alu_res = op_a << shamt;
            4'd6:    alu_res = op_a >> shamt;
            4'd7:    alu_res = $signed(op_a) >>> shamt;
            4'd8:    alu_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            4'd9:    alu_res = {{(XLEN-1){1'b0}}, op_a < op_b};
            default: alu_res = '0;
        endcase

        // Operand signedness from funct3; MUL's low half is sign-agnostic so it runs unsigned.
        md_div   = bus.muldiv_op[2];
        a_signed = md_div ? ~bus.muldiv_op[0]
                          : (bus.muldiv_op[1:0] == 2'b01) || (bus.muldiv_op[1:0] == 2'b10);
        b_signed = md_div ? ~bus.muldiv_op[0] : (bus.muldiv_op[1:0] == 2'b01);
        sa       = a_signed & op_a[XLEN-1];
        sb       = b_signed & reg_b[XLEN-1];
        mag_a    = sa ? -op_a : op_a;
        mag_b    = sb ? -reg_b : reg_b;
        b_zero   = (reg_b == '0);
        start    = (state_q == StIdle) & bus.id_valid & bus.is_muldiv & ~bus.flush;

        sum      = {1'b0, acc_q} + (lo_q[0] ? {1'b0, addend_q} : '0);
        shifted  = {acc_q, lo_q[XLEN-1]};
        diff     = shifted - {1'b0, addend_q};

        prod     = {acc_q, lo_q};
        prod_fix = neg_quo_q ? -prod : prod;
        quo_fix  = neg_quo_q ? -lo_q : lo_q;
        rem_fix  = neg_rem_q ? -acc_q : acc_q;
        case (op_q)
            3'd0:       md_res = prod_fix[XLEN-1:0];
            3'd1, 3'd2, 3'd3: md_res = prod_fix[2*XLEN-1:XLEN];
            3'd4, 3'd5: md_res = quo_fix;
            default:    md_res = rem_fix;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        acc_d          = acc_q;
        lo_d           = lo_q;
        addend_d       = addend_q;
        regb_d         = regb_q;
        op_d           = op_q;
        neg_quo_d      = neg_quo_q;
        neg_rem_d      = neg_rem_q;
        result_d       = result_q;
        rs2_fwd_d      = rs2_fwd_q;
        zero_flag_d    = zero_flag_q;
        result_valid_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d   = StBusy;
                    cnt_d     = '0;
                    acc_d     = '0;
                    addend_d  = md_div ? mag_b : mag_a;
                    lo_d      = md_div ? mag_a : mag_b;
                    regb_d    = reg_b;
                    op_d      = bus.muldiv_op;
                    // A zero divisor yields all-ones regardless of sign, so never negate it.
                    neg_quo_d = (sa ^ sb) & ~(md_div & b_zero);
                    neg_rem_d = sa;
`ifdef EX_MULDIV_EARLY_EN
                    if (md_div && b_zero) begin
                        lo_d    = '1;
                        acc_d   = mag_a;
                        state_d = StDone;
                    end else if (md_div && !bus.muldiv_op[0] && reg_b == '1 &&
                                 op_a == {1'b1, {(XLEN-1){1'b0}}}) begin
                        // |dividend| already sits in lo with a zero remainder: quotient is it.
                        state_d = StDone;
                    end else if (!md_div && (op_a == '0 || b_zero)) begin
                        lo_d    = '0;
                        state_d = StDone;
                    end
`endif
                end else if (bus.id_valid && !bus.is_muldiv && !bus.flush) begin
                    result_d       = alu_res;
                    zero_flag_d    = (alu_res == '0);
                    rs2_fwd_d      = reg_b;
                    result_valid_d = 1'b1;
                end
            end
            StBusy: begin
                if (op_q[2]) begin
                    if (!diff[XLEN]) begin
                        acc_d = diff[XLEN-1:0];
                        lo_d  = {lo_q[XLEN-2:0], 1'b1};
                    end else begin
                        acc_d = shifted[XLEN-1:0];
                        lo_d  = {lo_q[XLEN-2:0], 1'b0};
                    end
                end else begin
                    acc_d = sum[XLEN:1];
                    lo_d  = {sum[0], lo_q[XLEN-1:1]};
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(XLEN - 1)) state_d = StDone;
            end
            StDone: begin
                state_d = StIdle;
                if (!bus.flush) begin
                    result_d       = md_res;
                    zero_flag_d    = (md_res == '0);
                    rs2_fwd_d      = regb_q;
                    result_valid_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (bus.flush) state_d = StIdle;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            cnt_q          <= '0;
            acc_q          <= '0;
            lo_q           <= '0;
            addend_q       <= '0;
            regb_q         <= '0;
            op_q           <= '0;
            neg_quo_q      <= 1'b0;
            neg_rem_q      <= 1'b0;
            result_q       <= '0;
            rs2_fwd_q      <= '0;
            result_valid_q <= 1'b0;
            zero_flag_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            acc_q          <= acc_d;
            lo_q           <= lo_d;
            addend_q       <= addend_d;
            regb_q         <= regb_d;
            op_q           <= op_d;
            neg_quo_q      <= neg_quo_d;
            neg_rem_q      <= neg_rem_d;
            result_q       <= result_d;
            rs2_fwd_q      <= rs2_fwd_d;
            result_valid_q <= result_valid_d;
            zero_flag_q    <= zero_flag_d;
        end
    end

    // Gated by rst_n so the front end is never held while the block is in reset.
    assign bus.ex_stall     = rst_n & (start | (state_q == StBusy));
    assign bus.result       = result_q;
    assign bus.result_valid = result_valid_q;
    assign bus.zero_flag    = zero_flag_q;
    assign bus.rs2_fwd      = rs2_fwd_q;
endmodule

// File: tb/tb_ex_stage_mc.sv
module tb_ex_stage_mc;
    localparam int unsigned XLEN = 32;
`ifdef EX_MULDIV_EARLY_EN
    localparam int SPECIAL_STALL = 1;
`else
    localparam int SPECIAL_STALL = XLEN + 1;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    ex_stage_mc_if #(.XLEN(XLEN)) bus ();
    ex_stage_mc #(.XLEN(XLEN)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference arithmetic ----------------
    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        int unsigned sh;
        sh = b[4:0];
        case (op)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a & b;
            4'd3: return a | b;
            4'd4: return a ^ b;
            4'd5: return a << sh;
            4'd6: return a >> sh;
            4'd7: return $signed(a) >>> sh;
            4'd8: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd9: return (a < b) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        longint sa, sb, p;
        longint unsigned ua, ub, pu;
        int ia, ib;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        ia = $signed(a);
        ib = $signed(b);
        case (op)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'(ub); return p[63:32]; end
            3'd3: begin pu = ua * ub; return pu[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return ia / ib;
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return ia % ib;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int md_stall(input logic [2:0] op, input logic [31:0] a,
                                    input logic [31:0] b);
        bit special;
        if (op[2]) special = (b == 0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
        else       special = (a == 0) || (b == 0);
        return special ? SPECIAL_STALL : XLEN + 1;
    endfunction

    function automatic logic [31:0] mux(input logic [1:0] sel, input logic [31:0] rf);
        if (sel == 2'b01) return bus.alu_result_mem;
        if (sel == 2'b10) return bus.wb_data;
        return rf;
    endfunction

    // ---------------- behavioural model ----------------
    // A mul/div accepted in cycle T delivers at the end of cycle done_cyc; until then the
    // front end is stalled. cyc is the number of the current cycle.
    logic [31:0] m_result = '0, m_rs2 = '0, p_res = '0, p_rs2 = '0;
    logic        m_valid = 1'b0, m_zero = 1'b0;
    bit          pend = 1'b0;
    int          done_cyc = 0, cyc = 0;

    always @(posedge clk or negedge rst_n) begin
        logic [31:0] a, rb, b;
        if (!rst_n) begin
            m_result = '0; m_rs2 = '0; m_valid = 1'b0; m_zero = 1'b0; pend = 1'b0; cyc = 0;
        end else begin
            a  = mux(bus.forward_a, bus.rs1_data);
            rb = mux(bus.forward_b, bus.rs2_data);
            b  = bus.alu_src ? bus.immediate : rb;
            m_valid = 1'b0;
            if (bus.flush) begin
                pend = 1'b0;
            end else if (pend) begin
                if (cyc == done_cyc) begin
                    m_result = p_res; m_rs2 = p_rs2; m_zero = (p_res == 0); m_valid = 1'b1;
                    pend = 1'b0;
                end
            end else if (bus.id_valid) begin
                if (bus.is_muldiv) begin
                    pend     = 1'b1;
                    done_cyc = cyc + md_stall(bus.muldiv_op, a, rb);
                    p_res    = ref_md(bus.muldiv_op, a, rb);
                    p_rs2    = rb;
                end else begin
                    m_result = ref_alu(bus.alu_op, a, b);
                    m_rs2    = rb;
                    m_zero   = (m_result == 0);
                    m_valid  = 1'b1;
                end
            end
            cyc++;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        logic exp_stall;
        if (pend) exp_stall = (cyc < done_cyc);
        else      exp_stall = bus.id_valid & bus.is_muldiv & ~bus.flush;
        exp_stall = exp_stall & rst_n;
        check("ex_stall", {31'd0, bus.ex_stall}, {31'd0, exp_stall});
        check("result_valid", {31'd0, bus.result_valid}, {31'd0, m_valid});
        check("result", bus.result, m_result);
        check("zero_flag", {31'd0, bus.zero_flag}, {31'd0, m_zero});
        check("rs2_fwd", bus.rs2_fwd, m_rs2);
    end

    // ---------------- stimulus ----------------
    // Entered at posedge+1 with the instruction on the bus; returns at posedge+1 after the
    // cycle in which the instruction left EX (stall low, or flushed at relative cycle flush_at).
    task automatic issue(input int flush_at, input bit scramble, output int stalls);
        int k;
        logic st;
        k = 0;
        stalls = 0;
        forever begin
            bus.flush = (k == flush_at);
            @(negedge clk);
            st = bus.ex_stall;
            if (st) stalls++;
            @(posedge clk);
            #1;
            if (k == flush_at || !st) break;
            k++;
            if (k > 200) begin
                errors++;
                $display("FAIL stall_timeout: got stall after %0d cycles want release", k);
                break;
            end
            if (scramble) begin
                bus.alu_result_mem = $urandom;
                bus.wb_data        = $urandom;
            end
        end
        bus.flush = 1'b0;
    endtask

    task automatic set_alu(input logic [3:0] op, input logic [31:0] r1, input logic [31:0] r2,
                           input logic src, input logic [31:0] imm);
        bus.id_valid = 1'b1; bus.is_muldiv = 1'b0; bus.alu_op = op;
        bus.rs1_data = r1; bus.rs2_data = r2; bus.alu_src = src; bus.immediate = imm;
        bus.forward_a = 2'b00; bus.forward_b = 2'b00;
    endtask

    task automatic set_md(input logic [2:0] op, input logic [31:0] r1, input logic [31:0] r2);
        bus.id_valid = 1'b1; bus.is_muldiv = 1'b1; bus.muldiv_op = op;
        bus.rs1_data = r1; bus.rs2_data = r2; bus.alu_src = 1'b0;
        bus.forward_a = 2'b00; bus.forward_b = 2'b00;
    endtask

    function automatic logic [31:0] rand_val();
        case ($urandom_range(0, 6))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    int st;

    initial begin
        bus.id_valid = 0; bus.rs1_data = 0; bus.rs2_data = 0; bus.immediate = 0;
        bus.alu_src = 0; bus.alu_op = 0; bus.is_muldiv = 0; bus.muldiv_op = 0;
        bus.forward_a = 0; bus.forward_b = 0; bus.alu_result_mem = 0; bus.wb_data = 0;
        bus.flush = 0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_result", bus.result, 32'd0);
        check("reset_valid", {31'd0, bus.result_valid}, 32'd0);
        check("reset_stall", {31'd0, bus.ex_stall}, 32'd0);
        rst_n = 1'b1;

        // ADD with MEM forward on A and immediate B
        set_alu(4'd0, 32'd5, 32'd0, 1'b1, 32'd7);
        bus.forward_a = 2'b01; bus.alu_result_mem = 32'd100;
        issue(-1, 1'b0, st);
        bus.id_valid = 1'b0;
        check("t1_result", bus.result, 32'd107);
        check("t1_valid", {31'd0, bus.result_valid}, 32'd1);
        check("t1_zero", {31'd0, bus.zero_flag}, 32'd0);
        check("t1_stall", {31'd0, bus.ex_stall}, 32'd0);

        // Store address/data: WB forward on B, alu_src ignored for rs2_fwd
        set_alu(4'd0, 32'h1000, 32'd1, 1'b1, 32'd8);
        bus.forward_b = 2'b10; bus.wb_data = 32'hDEAD_BEEF;
        issue(-1, 1'b0, st);
        bus.id_valid = 1'b0;
        check("t2_result", bus.result, 32'h1008);
        check("t2_rs2_fwd", bus.rs2_fwd, 32'hDEAD_BEEF);

        // MULH then MUL of 0xFFFFFFFF x 3, operand A via MEM forward, scrambled while busy
        set_md(3'd1, 32'd0, 32'd3);
        bus.forward_a = 2'b01; bus.alu_result_mem = 32'hFFFF_FFFF;
        issue(-1, 1'b1, st);
        check("t3_mulh_stall", st, 32'd33);
        check("t3_mulh", bus.result, 32'hFFFF_FFFF);
        check("t3_mulh_valid", {31'd0, bus.result_valid}, 32'd1);
        set_md(3'd0, 32'hFFFF_FFFF, 32'd3);
        issue(-1, 1'b1, st);
        bus.id_valid = 1'b0;
        check("t3_mul_stall", st, 32'd33);
        check("t3_mul", bus.result, 32'hFFFF_FFFD);

        // Division corner cases
        set_md(3'd4, 32'd7, 32'd0);
        issue(-1, 1'b0, st);
        check("t4_div0", bus.result, 32'hFFFF_FFFF);
        check("t4_div0_stall", st, SPECIAL_STALL);
        set_md(3'd6, 32'd7, 32'd0);
        issue(-1, 1'b0, st);
        check("t4_rem0", bus.result, 32'd7);
        set_md(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
        issue(-1, 1'b0, st);
        check("t4_divovf", bus.result, 32'h8000_0000);
        check("t4_divovf_stall", st, SPECIAL_STALL);
        set_md(3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
        issue(-1, 1'b0, st);
        bus.id_valid = 1'b0;
        check("t4_removf", bus.result, 32'd0);
        check("t4_removf_zero", {31'd0, bus.zero_flag}, 32'd1);

        // DIVU flushed in its 10th busy cycle, then ADD 2+2
        set_md(3'd5, 32'd100, 32'd7);
        issue(10, 1'b0, st);
        bus.id_valid = 1'b0;
        check("t5_stall_after_flush", {31'd0, bus.ex_stall}, 32'd0);
        check("t5_valid_after_flush", {31'd0, bus.result_valid}, 32'd0);
        set_alu(4'd0, 32'd2, 32'd9, 1'b1, 32'd2);
        issue(-1, 1'b0, st);
        bus.id_valid = 1'b0;
        check("t5_add", bus.result, 32'd4);
        check("t5_add_valid", {31'd0, bus.result_valid}, 32'd1);

        // Asynchronous reset in the 5th busy cycle
        set_md(3'd5, 32'd1000, 32'd3);
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_stall", {31'd0, bus.ex_stall}, 32'd0);
        check("t6_valid", {31'd0, bus.result_valid}, 32'd0);
        check("t6_result", bus.result, 32'd0);
        check("t6_rs2_fwd", bus.rs2_fwd, 32'd0);
        @(posedge clk);
        #1;
        bus.id_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        set_alu(4'd0, 32'd20, 32'd22, 1'b0, 32'd0);
        issue(-1, 1'b0, st);
        bus.id_valid = 1'b0;
        check("t6_add", bus.result, 32'd42);

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            bus.id_valid       = 1'b1;
            bus.is_muldiv      = ($urandom_range(0, 9) < 3);
            bus.muldiv_op      = 3'($urandom_range(0, 7));
            bus.alu_op         = 4'($urandom_range(0, 15));
            bus.forward_a      = 2'($urandom_range(0, 3));
            bus.forward_b      = 2'($urandom_range(0, 3));
            bus.alu_src        = 1'($urandom_range(0, 1));
            bus.rs1_data       = rand_val();
            bus.rs2_data       = rand_val();
            bus.immediate      = rand_val();
            bus.alu_result_mem = rand_val();
            bus.wb_data        = rand_val();
            issue(($urandom_range(0, 19) == 0) ? int'($urandom_range(0, XLEN + 1)) : -1,
                  1'($urandom_range(0, 1)), st);
            if ($urandom_range(0, 3) == 0) begin
                bus.id_valid = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        bus.id_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish want finish before time limit");
        $fatal(1);
    end
endmodule
